execute_md: RTL and testbench
=============================

# execute_md

Parametrised execute stage for the 5-stage MIPS pipeline that adds an iterative multiply/divide unit with HI/LO registers. It does operand forwarding, source selection, the ALU operation and destination-register selection. It issues a stall request to the hazard unit while HI/LO results are pending, and it contains the E→M pipeline register. It sits between the decode-stage register and the memory stage.

## Interface
- WIDTH, 32: datapath width (even, ≥8)
- ADDR_W, 5: register-address width
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- reg_write_e_i, mem_write_e_i, mem_to_reg_e_i, reg_dst_e_i  in  1 each  E-stage controls
- alu_src_e_i  in  2  [1]: srcA = zero-extended shamt; [0]: srcB = sign_imm
- alu_control_e_i  in  4  ALU function (codebase alu encoding)
- jump_e_i  in  3  [2] = link: destination forced to register 31
- md_op_e_i  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9–15 treated as none
- reg_data_1_e_i, reg_data_2_e_i, sign_imm_e_i, alu_out_m_i, result_w_i  in  WIDTH
- rt_e_i, rd_e_i, shamt_e_i  in  ADDR_W
- forward_a_e_i, forward_b_e_i  in  2  00 register file, 01 result_w, 10 alu_out_m, 11 register file
- md_stall_e_o  out  1  combinational stall request to the hazard unit
- write_reg_e_o  out  ADDR_W  combinational E-stage destination
- reg_write_m_o, mem_write_m_o, mem_to_reg_m_o  out  1  registered controls
- alu_out_m_o, write_data_m_o  out  WIDTH  registered results
- write_reg_m_o  out  ADDR_W  registered destination

## Operation
- **Forwarding.** fwdA/fwdB are taken from the forward muxes.
- **Source selection.** srcA = alu_src[1] ? zext(shamt) : fwdA. srcB = alu_src[0] ? sign_imm : fwdB. write_data_e = fwdB.
- **Destination.** write_reg_e_o = jump[2] ? all-ones (31) : (reg_dst ? rd : rt).
- **E result.**
  - MFHI → HI; MFLO → LO.
  - Otherwise → ALU(srcA, srcB).
- **MD FSM: IDLE.**
  - MULT/MULTU/DIV/DIVU with no stall → latch fwdA, fwdB (magnitudes plus sign flags for signed ops) and load count = WIDTH; go to BUSY.
  - MTHI/MTLO with no stall → write fwdA into HI/LO.
- **MD FSM: BUSY.**
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring step per cycle.
  - count decrements each cycle.
  - At count == 1: write HI/LO with final sign correction applied combinationally, then go to IDLE.
- **Multiply result.** {HI, LO} = 2·WIDTH-bit product. Signed when MULT.
- **Divide result.**
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Divisor 0: LO = all ones, HI = dividend. The unit still takes WIDTH cycles.
- **Stall.**
  - md_stall_e_o = BUSY && md_op ∈ {1..8}.
  - Non-MD instructions never stall; MULT itself does not stall in IDLE.
- **E→M register.**
  - Stall or rst_i: load a bubble (all controls 0, data 0).
  - Otherwise: load controls, E result, write_data_e and write_reg_e_o.
- **Accepted MD operations.** MULT/DIV/MTHI/MTLO pass with reg_write as decoded (0 from the decoder).

## Timing
- Reset:
  - All _m outputs are 0.
  - HI = LO = 0, FSM = IDLE, count = 0.
  - md_stall_e_o = 0.
- ALU path: E→M latency of 1 cycle.
- MD op accepted at the edge ending cycle N:
  - BUSY during cycles N+1 … N+WIDTH.
  - HI/LO are updated at the edge ending cycle N+WIDTH.
  - MFHI/MFLO in E is stalled for cycles N+1 … N+WIDTH and proceeds in cycle N+WIDTH+1 with the new value.
- Back-to-back MD ops: the second one stalls until IDLE. It is accepted in cycle N+WIDTH+1. There is no overlap.
- MTHI/MTLO while BUSY: stalled; the write lands after completion (MTxx wins).
- Reset mid-operation: aborts the operation. HI/LO return to 0; partial results are discarded.
- Forwarding selects 11 behave as 00.

## Test plan
- **Reset.** Assert rst_i for 2 cycles during BUSY → all outputs 0, stall 0; a later MFHI returns 0.
- **ALU with forwarding.** ADD with forward_a=10 (alu_out_m=5), forward_b=01 (result_w=7) → alu_out_m_o=12 one cycle later. The LINK case gives write_reg_m_o=31.
- **Signed multiply.** MULT of -3 × 7 (WIDTH=32), then MFLO on the next instruction → stall exactly 32 cycles; LO=0xFFFFFFEB, HI=0xFFFFFFFF; bubbles appear in M while stalled.
- **Signed divide.** DIV of -7 / 2 → LO=-3, HI=-1. DIVU of 7/0 → LO=0xFFFFFFFF, HI=7, after 32 cycles.
- **Back-to-back and MTHI.** MULTU then DIVU back-to-back → second stalls until IDLE; final HI/LO reflect DIVU. MTHI 0x1234 while BUSY → stalls, then HI=0x1234.
- **Width parameter.** WIDTH=16: MULTU 0xFFFF × 0xFFFF → HI=0xFFFE, LO=0x0001 after 16 busy cycles.

Source files
------------

// File: rtl/execute_md.sv
// Execute stage for the 5-stage MIPS pipeline: forwarding, ALU, destination select,
// an iterative multiply/divide unit with HI/LO, stall request and the E->M register.
module execute_md #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_write_e_i,
    input  logic              mem_write_e_i,
    input  logic              mem_to_reg_e_i,
    input  logic              reg_dst_e_i,
    input  logic [1:0]        alu_src_e_i,
    input  logic [3:0]        alu_control_e_i,
    input  logic [2:0]        jump_e_i,
    input  logic [3:0]        md_op_e_i,
    input  logic [WIDTH-1:0]  reg_data_1_e_i,
    input  logic [WIDTH-1:0]  reg_data_2_e_i,
    input  logic [WIDTH-1:0]  sign_imm_e_i,
    input  logic [WIDTH-1:0]  alu_out_m_i,
    input  logic [WIDTH-1:0]  result_w_i,
    input  logic [ADDR_W-1:0] rt_e_i,
    input  logic [ADDR_W-1:0] rd_e_i,
    input  logic [ADDR_W-1:0] shamt_e_i,
    input  logic [1:0]        forward_a_e_i,
    input  logic [1:0]        forward_b_e_i,
    output logic              md_stall_e_o,
    output logic [ADDR_W-1:0] write_reg_e_o,
    output logic              reg_write_m_o,
    output logic              mem_write_m_o,
    output logic              mem_to_reg_m_o,
    output logic [WIDTH-1:0]  alu_out_m_o,
    output logic [WIDTH-1:0]  write_data_m_o,
    output logic [ADDR_W-1:0] write_reg_m_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SH_W  = $clog2(WIDTH);

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_t;

    // ALU: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 6 SUB, 7 SLT, 8 SLL, 9 SRL, A SRA, B SLTU, C LUI
    function automatic logic [WIDTH-1:0] alu(input logic [3:0] ctl,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SH_W-1:0]         sh;
        sa = a;
        sb = b;
        sh = a[SH_W-1:0];
        case (ctl)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a ^ b;
            4'h4:    return ~(a | b);
            4'h6:    return a - b;
            4'h7:    return {{(WIDTH-1){1'b0}}, (sa < sb)};
            4'h8:    return b << sh;
            4'h9:    return b >> sh;
            4'hA:    return sb >>> sh;
            4'hB:    return {{(WIDTH-1){1'b0}}, (a < b)};
            4'hC:    return b << (WIDTH / 2);
            default: return '0;
        endcase
    endfunction

    // Two's-complement negate when neg is set (magnitude extraction and sign correction).
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_negate2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    logic [WIDTH-1:0]   fwd_a, fwd_b, src_a, src_b, result_e;
    md_state_t          state, state_n;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   opb, hi, lo, hi_fin, lo_fin;
    logic               is_div, neg_q, neg_r, div0;
    logic               accept, finish, is_md_op, is_start;
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_n;
    logic               unused;

    assign unused = ^{jump_e_i[1:0], div_diff[WIDTH]};

    // Operand forwarding, source selection, destination and E result.
    always_comb begin
        case (forward_a_e_i)
            2'b01:   fwd_a = result_w_i;
            2'b10:   fwd_a = alu_out_m_i;
            default: fwd_a = reg_data_1_e_i;
        endcase
        case (forward_b_e_i)
            2'b01:   fwd_b = result_w_i;
            2'b10:   fwd_b = alu_out_m_i;
            default: fwd_b = reg_data_2_e_i;
        endcase
        src_a = alu_src_e_i[1] ? {{(WIDTH-ADDR_W){1'b0}}, shamt_e_i} : fwd_a;
        src_b = alu_src_e_i[0] ? sign_imm_e_i : fwd_b;
        write_reg_e_o = jump_e_i[2] ? {ADDR_W{1'b1}} : (reg_dst_e_i ? rd_e_i : rt_e_i);
        case (md_op_e_i)
            MD_MFHI: result_e = hi;
            MD_MFLO: result_e = lo;
            default: result_e = alu(alu_control_e_i, src_a, src_b);
        endcase
    end

    assign is_md_op  = (md_op_e_i >= MD_MULT) && (md_op_e_i <= MD_MTLO);
    assign is_start  = (md_op_e_i >= MD_MULT) && (md_op_e_i <= MD_DIVU);
    assign signed_op = (md_op_e_i == MD_MULT) || (md_op_e_i == MD_DIV);
    assign a_neg     = signed_op & fwd_a[WIDTH-1];
    assign b_neg     = signed_op & fwd_b[WIDTH-1];

    // MD state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_n;
    end

    // MD next state, accept/finish strobes and stall request.
    always_comb begin
        state_n      = state;
        accept       = 1'b0;
        finish       = 1'b0;
        md_stall_e_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_start) begin
                    accept  = 1'b1;
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                md_stall_e_o = is_md_op;
                if (count == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One shift-add or restoring-divide step, plus the sign-corrected final HI/LO.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ge    = (div_shift >= {1'b0, opb});
        rem_n     = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        acc_step  = is_div ? {rem_n, acc[WIDTH-2:0], div_ge} : {mul_sum, acc[WIDTH-1:1]};
        prod      = cond_negate2(acc_step, neg_q);
        if (is_div) begin
            // divide by zero: the raw restoring loop leaves the dividend in the remainder
            lo_fin = div0 ? {WIDTH{1'b1}} : cond_negate(acc_step[WIDTH-1:0], neg_q);
            hi_fin = cond_negate(acc_step[2*WIDTH-1:WIDTH], neg_r);
        end else begin
            lo_fin = prod[WIDTH-1:0];
            hi_fin = prod[2*WIDTH-1:WIDTH];
        end
    end

    // MD datapath: operand latch, iteration, HI/LO writes (MTHI/MTLO only when idle).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi    <= '0;
            lo    <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                acc    <= {{WIDTH{1'b0}}, cond_negate(fwd_a, a_neg)};
                opb    <= cond_negate(fwd_b, b_neg);
                is_div <= (md_op_e_i == MD_DIV) || (md_op_e_i == MD_DIVU);
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                div0   <= (fwd_b == '0);
                count  <= CNT_W'(WIDTH);
            end else if (state == S_BUSY) begin
                acc   <= acc_step;
                count <= count - CNT_W'(1);
                if (finish) begin
                    hi <= hi_fin;
                    lo <= lo_fin;
                end
            end
            if (state == S_IDLE && md_op_e_i == MD_MTHI) hi <= fwd_a;
            if (state == S_IDLE && md_op_e_i == MD_MTLO) lo <= fwd_a;
        end
    end

    // E->M pipeline register; a stall inserts a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i || md_stall_e_o) begin
            reg_write_m_o  <= 1'b0;
            mem_write_m_o  <= 1'b0;
            mem_to_reg_m_o <= 1'b0;
            alu_out_m_o    <= '0;
            write_data_m_o <= '0;
            write_reg_m_o  <= '0;
        end else begin
            reg_write_m_o  <= reg_write_e_i;
            mem_write_m_o  <= mem_write_e_i;
            mem_to_reg_m_o <= mem_to_reg_e_i;
            alu_out_m_o    <= result_e;
            write_data_m_o <= fwd_b;
            write_reg_m_o  <= write_reg_e_o;
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: ALU/forwarding, MD unit timing and results, reset abort,
// plus a 16-bit instance for the width parameter.
module tb_execute_md;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        reg_write_e, mem_write_e, mem_to_reg_e, reg_dst_e;
    logic [1:0]  alu_src_e, forward_a_e, forward_b_e;
    logic [3:0]  alu_control_e, md_op_e;
    logic [2:0]  jump_e;
    logic [31:0] reg_data_1_e, reg_data_2_e, sign_imm_e, alu_out_m_in, result_w;
    logic [4:0]  rt_e, rd_e, shamt_e;
    logic        md_stall, reg_write_m, mem_write_m, mem_to_reg_m;
    logic [4:0]  write_reg_e, write_reg_m;
    logic [31:0] alu_out_m, write_data_m;

    logic [3:0]  md_op16;
    logic [15:0] rd1_16, rd2_16;
    logic        rw16, stall16, rwm16, mwm16, mtrm16;
    logic [4:0]  wre16, wrm16;
    logic [15:0] aom16, wdm16;

    int n_chk, n_fail, n_st, n_bad;

    execute_md #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk_i(clk), .rst_i(rst),
        .reg_write_e_i(reg_write_e), .mem_write_e_i(mem_write_e),
        .mem_to_reg_e_i(mem_to_reg_e), .reg_dst_e_i(reg_dst_e),
        .alu_src_e_i(alu_src_e), .alu_control_e_i(alu_control_e),
        .jump_e_i(jump_e), .md_op_e_i(md_op_e),
        .reg_data_1_e_i(reg_data_1_e), .reg_data_2_e_i(reg_data_2_e),
        .sign_imm_e_i(sign_imm_e), .alu_out_m_i(alu_out_m_in), .result_w_i(result_w),
        .rt_e_i(rt_e), .rd_e_i(rd_e), .shamt_e_i(shamt_e),
        .forward_a_e_i(forward_a_e), .forward_b_e_i(forward_b_e),
        .md_stall_e_o(md_stall), .write_reg_e_o(write_reg_e),
        .reg_write_m_o(reg_write_m), .mem_write_m_o(mem_write_m),
        .mem_to_reg_m_o(mem_to_reg_m), .alu_out_m_o(alu_out_m),
        .write_data_m_o(write_data_m), .write_reg_m_o(write_reg_m)
    );

    execute_md #(.WIDTH(16), .ADDR_W(5)) dut16 (
        .clk_i(clk), .rst_i(rst),
        .reg_write_e_i(rw16), .mem_write_e_i(1'b0),
        .mem_to_reg_e_i(1'b0), .reg_dst_e_i(1'b1),
        .alu_src_e_i(2'b00), .alu_control_e_i(4'h2),
        .jump_e_i(3'b000), .md_op_e_i(md_op16),
        .reg_data_1_e_i(rd1_16), .reg_data_2_e_i(rd2_16),
        .sign_imm_e_i(16'h0000), .alu_out_m_i(16'h0000), .result_w_i(16'h0000),
        .rt_e_i(5'd0), .rd_e_i(5'd9), .shamt_e_i(5'd0),
        .forward_a_e_i(2'b00), .forward_b_e_i(2'b00),
        .md_stall_e_o(stall16), .write_reg_e_o(wre16),
        .reg_write_m_o(rwm16), .mem_write_m_o(mwm16),
        .mem_to_reg_m_o(mtrm16), .alu_out_m_o(aom16),
        .write_data_m_o(wdm16), .write_reg_m_o(wrm16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nop;
        reg_write_e = 0; mem_write_e = 0; mem_to_reg_e = 0; reg_dst_e = 0;
        alu_src_e = 0; alu_control_e = 0; jump_e = 0; md_op_e = 0;
        forward_a_e = 0; forward_b_e = 0;
    endtask

    // Hold current inputs while the selected DUT stalls; count stall cycles and non-bubbles.
    task automatic wait_stall(input bit w16, output int n, output int bad);
        n = 0;
        bad = 0;
        #1;
        while ((w16 ? stall16 : md_stall) && n < 40) begin
            tick;
            n++;
            if (w16 ? (rwm16 !== 1'b0 || aom16 !== 16'h0)
                    : (reg_write_m !== 1'b0 || alu_out_m !== 32'h0)) bad++;
        end
    endtask

    // Issue MFxx to the 32-bit DUT with a live destination (rd = 8).
    task automatic mfxx(input logic [3:0] op);
        nop;
        md_op_e = op; reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd8;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        nop;
        reg_data_1_e = 0; reg_data_2_e = 0; sign_imm_e = 0; alu_out_m_in = 0; result_w = 0;
        rt_e = 0; rd_e = 0; shamt_e = 0;
        md_op16 = 0; rd1_16 = 0; rd2_16 = 0; rw16 = 0;
        rst = 1;
        tick; tick;
        chk("rst_alu_out", alu_out_m, 0);
        chk("rst_reg_write", reg_write_m, 0);
        chk("rst_write_reg", write_reg_m, 0);
        chk("rst_stall", md_stall, 0);
        chk("rst_stall16", stall16, 0);
        rst = 0;

        // ADD with forwarding: 5 (M) + 7 (W)
        reg_write_e = 1; reg_dst_e = 1; rd_e = 5'd5; rt_e = 5'd6; alu_control_e = 4'h2;
        forward_a_e = 2'b10; alu_out_m_in = 5; forward_b_e = 2'b01; result_w = 7;
        reg_data_1_e = 100; reg_data_2_e = 200;
        #1 chk("dest_rd_e", write_reg_e, 5);
        tick;
        chk("add_fwd", alu_out_m, 12);
        chk("add_fwd_wdata", write_data_m, 7);
        chk("add_fwd_wreg", write_reg_m, 5);
        chk("add_fwd_rw", reg_write_m, 1);
        forward_a_e = 2'b11; forward_b_e = 2'b11; reg_dst_e = 0;
        tick;
        chk("add_fwd11", alu_out_m, 300);
        chk("fwd11_wdata", write_data_m, 200);
        chk("dest_rt", write_reg_m, 6);
        alu_src_e = 2'b11; shamt_e = 5'd4; sign_imm_e = 3; alu_control_e = 4'h8;
        tick;
        chk("sll_shamt_imm", alu_out_m, 48);
        alu_src_e = 2'b01; sign_imm_e = 32'hFFFFFFFF; alu_control_e = 4'h6; forward_a_e = 2'b00;
        tick;
        chk("sub_imm", alu_out_m, 101);
        alu_src_e = 0; jump_e = 3'b100; reg_dst_e = 1; alu_control_e = 4'h2;
        #1 chk("link_e", write_reg_e, 31);
        tick;
        chk("link_m", write_reg_m, 31);

        // MULT -3 * 7, then MFLO
        nop; md_op_e = 4'd1; reg_data_1_e = 32'hFFFFFFFD; reg_data_2_e = 7;
        #1 chk("mult_no_stall", md_stall, 0);
        tick;
        mfxx(4'd6);
        wait_stall(1'b0, n_st, n_bad);
        chk("mult_stall_cycles", n_st, 32);
        chk("mult_bubbles", n_bad, 0);
        tick;
        chk("mult_lo", alu_out_m, 32'hFFFFFFEB);
        chk("mflo_wreg", write_reg_m, 8);
        mfxx(4'd5);
        tick;
        chk("mult_hi", alu_out_m, 32'hFFFFFFFF);

        // DIV -7 / 2
        nop; md_op_e = 4'd3; reg_data_1_e = 32'hFFFFFFF9; reg_data_2_e = 2;
        tick;
        mfxx(4'd6);
        wait_stall(1'b0, n_st, n_bad);
        tick;
        chk("div_lo", alu_out_m, 32'hFFFFFFFD);
        mfxx(4'd5);
        tick;
        chk("div_hi", alu_out_m, 32'hFFFFFFFF);

        // DIVU 7 / 0
        nop; md_op_e = 4'd4; reg_data_1_e = 7; reg_data_2_e = 0;
        tick;
        mfxx(4'd6);
        wait_stall(1'b0, n_st, n_bad);
        chk("div0_cycles", n_st, 32);
        tick;
        chk("div0_lo", alu_out_m, 32'hFFFFFFFF);
        mfxx(4'd5);
        tick;
        chk("div0_hi", alu_out_m, 7);

        // MULTU then DIVU back-to-back
        nop; md_op_e = 4'd2; reg_data_1_e = 32'h10000; reg_data_2_e = 32'h10000;
        tick;
        md_op_e = 4'd4; reg_data_1_e = 100; reg_data_2_e = 7;
        wait_stall(1'b0, n_st, n_bad);
        chk("b2b_stall", n_st, 32);
        tick;
        mfxx(4'd6);
        wait_stall(1'b0, n_st, n_bad);
        chk("b2b_second_busy", n_st, 32);
        tick;
        chk("b2b_lo", alu_out_m, 14);
        mfxx(4'd5);
        tick;
        chk("b2b_hi", alu_out_m, 2);

        // MTHI while MULTU 3*5 is busy
        nop; md_op_e = 4'd2; reg_data_1_e = 3; reg_data_2_e = 5;
        tick;
        md_op_e = 4'd7; reg_data_1_e = 32'h1234;
        wait_stall(1'b0, n_st, n_bad);
        chk("mthi_stall", n_st, 32);
        tick;
        mfxx(4'd5);
        tick;
        chk("mthi_hi", alu_out_m, 32'h1234);
        mfxx(4'd6);
        tick;
        chk("mthi_lo", alu_out_m, 15);

        // Reset during BUSY
        nop; md_op_e = 4'd2; reg_data_1_e = 32'hFFFFFFFF; reg_data_2_e = 2;
        tick;
        nop; reg_write_e = 1; alu_control_e = 4'h2; reg_data_1_e = 1; reg_data_2_e = 2;
        #1 chk("busy_alu_no_stall", md_stall, 0);
        tick;
        chk("busy_alu_flow", alu_out_m, 3);
        tick;
        mfxx(4'd5);
        rst = 1;
        tick; tick;
        chk("midrst_alu_out", alu_out_m, 0);
        chk("midrst_rw", reg_write_m, 0);
        chk("midrst_wdata", write_data_m, 0);
        rst = 0;
        #1 chk("midrst_stall", md_stall, 0);
        tick;
        chk("midrst_hi", alu_out_m, 0);
        mfxx(4'd6);
        tick;
        chk("midrst_lo", alu_out_m, 0);

        // WIDTH=16: MULTU 0xFFFF * 0xFFFF
        nop;
        md_op16 = 4'd2; rd1_16 = 16'hFFFF; rd2_16 = 16'hFFFF;
        tick;
        md_op16 = 4'd6; rw16 = 1;
        wait_stall(1'b1, n_st, n_bad);
        chk("w16_stall", n_st, 16);
        chk("w16_bubbles", n_bad, 0);
        tick;
        chk("w16_lo", aom16, 16'h0001);
        md_op16 = 4'd5;
        tick;
        chk("w16_hi", aom16, 16'hFFFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
